// File: rtl/jtkicker_sdram_arb.sv
// Four-slot ROM read arbiter in front of a single SDRAM read port.
// Each slot keeps one cached 32-bit word; misses are served round-robin, one burst at a time.
module jtkicker_sdram_arb #(
    parameter logic [21:0] OFFSET0 = 22'h0,
    parameter logic [21:0] OFFSET1 = 22'h0,
    parameter logic [21:0] OFFSET2 = 22'h0,
    parameter logic [21:0] OFFSET3 = 22'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         downloading,
    input  logic [3:0]   slot_cs,
    input  logic [87:0]  slot_addr,
    output logic [3:0]   slot_ok,
    output logic [127:0] slot_dout,
    output logic         sdram_req,
    output logic [21:0]  sdram_addr,
    input  logic         sdram_ack,
    input  logic         data_dst,
    input  logic         data_rdy,
    input  logic [15:0]  data_read
);

    // Handshake: sdram_req rises with a stable sdram_addr and both hold until the
    // one-cycle sdram_ack; the burst then returns two data_dst words, the second
    // one flagged by data_rdy. Only one burst is ever outstanding.
    typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

    state_t      state;
    logic [21:0] tag  [4];
    logic [31:0] data [4];
    logic [21:0] addr [4];
    logic [3:0]  valid;
    logic [3:0]  hit;
    logic [3:0]  miss;
    logic [1:0]  rr;
    logic [1:0]  grant;
    logic [1:0]  pick;
    logic [21:0] pend_tag;
    logic [15:0] lo_word;
    logic        req_r;

    function automatic logic [21:0] offset_of(input logic [1:0] n);
        case (n)
            2'd0:    offset_of = OFFSET0;
            2'd1:    offset_of = OFFSET1;
            2'd2:    offset_of = OFFSET2;
            default: offset_of = OFFSET3;
        endcase
    endfunction

    for (genvar n = 0; n < 4; n++) begin : g_slot
        assign addr[n] = slot_addr[22*n +: 22];
        assign hit[n]  = slot_cs[n] & valid[n] & (tag[n] == addr[n]);
    end

    assign slot_ok   = hit & {4{~downloading}};
    assign miss      = slot_cs & ~hit;
    assign slot_dout = {data[3], data[2], data[1], data[0]};
    assign sdram_req = req_r & ~downloading;

    // First missing slot at or after the round-robin pointer, wrapping modulo 4.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        pick  = rr;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = rr + 2'(k);
            if (!found && miss[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_r      <= 1'b0;
            sdram_addr <= '0;
            valid      <= '0;
            rr         <= '0;
            grant      <= '0;
            pend_tag   <= '0;
            lo_word    <= '0;
            for (int n = 0; n < 4; n++) begin
                tag[n]  <= '0;
                data[n] <= '0;
            end
        end else if (downloading) begin
            valid <= '0;
            req_r <= 1'b0;
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (|miss) begin
                        grant      <= pick;
                        pend_tag   <= addr[pick];
                        sdram_addr <= addr[pick] + offset_of(pick);
                        req_r      <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        req_r <= 1'b0;
                        if (data_dst) begin
                            lo_word <= data_read;
                            state   <= FILL;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (data_dst) begin
                        lo_word <= data_read;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    // Tag, data and valid are written together so a slot whose
                    // address moved mid-burst never sees data under a wrong tag.
                    if (data_dst && data_rdy) begin
                        data[grant]  <= {data_read, lo_word};
                        tag[grant]   <= pend_tag;
                        valid[grant] <= 1'b1;
                        rr           <= grant + 2'd1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtkicker_sdram_arb.sv
// Directed bench for jtkicker_sdram_arb: a hit/ok vector table plus hand-written
// burst sequences for arbitration order, stale requests, download and async reset.
module tb_jtkicker_sdram_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic         downloading;
    logic [3:0]   slot_cs;
    logic [87:0]  slot_addr;
    logic [3:0]   slot_ok;
    logic [127:0] slot_dout;
    logic         sdram_req;
    logic [21:0]  sdram_addr;
    logic         sdram_ack;
    logic         data_dst;
    logic         data_rdy;
    logic [15:0]  data_read;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [3:0]  cs;
        logic [87:0] addr;
        logic [3:0]  exp_ok;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    jtkicker_sdram_arb #(
        .OFFSET0(22'h080000),
        .OFFSET1(22'h100000),
        .OFFSET2(22'h3FFFF0),
        .OFFSET3(22'h000000)
    ) dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .slot_cs(slot_cs), .slot_addr(slot_addr),
        .slot_ok(slot_ok), .slot_dout(slot_dout),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .data_dst(data_dst),
        .data_rdy(data_rdy), .data_read(data_read)
    );

    function automatic logic [87:0] pack(input logic [21:0] a0, a1, a2, a3);
        pack = {a3, a2, a1, a0};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int n, input logic [21:0] a);
        slot_addr[22*n +: 22] = a;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        downloading = 1'b0;
        sdram_ack = 1'b0;
        data_dst = 1'b0;
        data_rdy = 1'b0;
        data_read = '0;
        slot_cs = '0;
        slot_addr = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_req(input string name, input logic [21:0] exp_addr);
        int n = 0;
        while (!sdram_req && n < 20) begin
            step();
            n++;
        end
        check({name, " req"}, sdram_req, 1'b1);
        check({name, " addr"}, sdram_addr, exp_addr);
    endtask

    // Serves one two-word burst; `same` puts the first word in the ack cycle.
    task automatic serve(input string name, input int slot, input logic [21:0] exp_addr,
                         input logic [15:0] w0, input logic [15:0] w1,
                         input logic same, input logic exp_ok);
        wait_req(name, exp_addr);
        sdram_ack = 1'b1;
        if (same) begin
            data_dst = 1'b1;
            data_read = w0;
            step();
            sdram_ack = 1'b0;
        end else begin
            step();
            sdram_ack = 1'b0;
            check({name, " req drop"}, sdram_req, 1'b0);
            data_dst = 1'b1;
            data_read = w0;
            step();
        end
        data_read = w1;
        data_rdy = 1'b1;
        step();
        data_dst = 1'b0;
        data_rdy = 1'b0;
        check({name, " dout"}, slot_dout[32*slot +: 32], {w1, w0});
        check({name, " ok"}, slot_ok[slot], exp_ok);
    endtask

    initial begin
        do_reset();
        rst = 1'b1;
        #1;
        check("reset req", sdram_req, 1'b0);
        check("reset addr", sdram_addr, 22'h0);
        check("reset ok", slot_ok, 4'h0);
        check("reset dout", slot_dout, 128'h0);
        step();
        rst = 1'b0;

        // Single miss on slot 0, then re-read and address change.
        slot_cs = 4'b0001;
        set_addr(0, 22'h000010);
        step();
        check("t1 req next cycle", sdram_req, 1'b1);
        check("t1 addr", sdram_addr, 22'h080010);
        serve("t1", 0, 22'h080010, 16'h1234, 16'h5678, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2 hit no req", sdram_req, 1'b0);
            check("t2 hit ok", slot_ok[0], 1'b1);
        end
        set_addr(0, 22'h000012);
        #1;
        check("t2 ok drops same cycle", slot_ok[0], 1'b0);
        serve("t2", 0, 22'h080012, 16'haaaa, 16'hbbbb, 1'b0, 1'b1);

        // Round-robin order with all four missing; slot 2 offset wraps.
        do_reset();
        slot_addr = pack(22'h20, 22'h40, 22'h60, 22'h80);
        slot_cs = 4'b1111;
        serve("rr s0", 0, 22'h080020, 16'h0001, 16'h1000, 1'b0, 1'b1);
        serve("rr s1", 1, 22'h100040, 16'h0002, 16'h2000, 1'b0, 1'b1);
        serve("rr s2", 2, 22'h000050, 16'h0003, 16'h3000, 1'b0, 1'b1);
        serve("rr s3", 3, 22'h000080, 16'h0004, 16'h4000, 1'b0, 1'b1);
        step();
        check("rr all hit idle", sdram_req, 1'b0);
        set_addr(0, 22'h22);
        set_addr(2, 22'h62);
        serve("rr wrap s0", 0, 22'h080022, 16'h0005, 16'h5000, 1'b0, 1'b1);
        serve("rr then s2", 2, 22'h000052, 16'h0006, 16'h6000, 1'b0, 1'b1);

        // Combinational hit table against caches 0x22/0x40/0x62/0x80.
        vecs[0] = '{4'b1111, pack(22'h22, 22'h40, 22'h62, 22'h80), 4'b1111};
        vecs[1] = '{4'b0101, pack(22'h22, 22'h40, 22'h62, 22'h80), 4'b0101};
        vecs[2] = '{4'b1111, pack(22'h22, 22'h42, 22'h62, 22'h80), 4'b1101};
        vecs[3] = '{4'b0000, pack(22'h22, 22'h40, 22'h62, 22'h80), 4'b0000};
        vecs[4] = '{4'b1111, pack(22'h20, 22'h40, 22'h62, 22'h82), 4'b0110};
        vecs[5] = '{4'b1000, pack(22'h00, 22'h00, 22'h00, 22'h80), 4'b1000};
        for (int i = 0; i < 6; i++) begin
            slot_cs = vecs[i].cs;
            slot_addr = vecs[i].addr;
            #2;
            check($sformatf("vec%0d ok", i), slot_ok, vecs[i].exp_ok);
            step();
        end
        check("vec dout", slot_dout, {32'h40000004, 32'h60000006, 32'h20000002, 32'h50000005});

        // Stale request: slot 1 address moves while the burst is in flight.
        do_reset();
        slot_cs = 4'b0010;
        set_addr(1, 22'h100);
        wait_req("stale", 22'h100100);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        set_addr(1, 22'h200);
        data_dst = 1'b1;
        data_read = 16'h1111;
        step();
        data_read = 16'h2222;
        data_rdy = 1'b1;
        step();
        data_dst = 1'b0;
        data_rdy = 1'b0;
        check("stale ok stays low", slot_ok[1], 1'b0);
        serve("stale refetch", 1, 22'h100200, 16'h3333, 16'h4444, 1'b1, 1'b1);

        // Download raised mid-FILL: gating, dropped word, cleared valids, refetch.
        slot_cs = 4'b0011;
        set_addr(0, 22'h30);
        wait_req("dl", 22'h080030);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        data_dst = 1'b1;
        data_read = 16'hdead;
        step();
        data_dst = 1'b0;
        downloading = 1'b1;
        #1;
        check("dl req low", sdram_req, 1'b0);
        check("dl ok low", slot_ok, 4'h0);
        data_dst = 1'b1;
        data_rdy = 1'b1;
        data_read = 16'hbeef;
        step();
        data_dst = 1'b0;
        data_rdy = 1'b0;
        step();
        check("dl word ignored", slot_dout[31:0], 32'h0);
        check("dl ok still low", slot_ok, 4'h0);
        downloading = 1'b0;
        #1;
        check("dl valid cleared", slot_ok, 4'h0);
        serve("dl refetch s0", 0, 22'h080030, 16'h5555, 16'h6666, 1'b0, 1'b1);
        serve("dl refetch s1", 1, 22'h100200, 16'h7777, 16'h8888, 1'b0, 1'b1);

        // Asynchronous reset while a request is pending.
        set_addr(0, 22'h34);
        wait_req("arst", 22'h080034);
        #2;
        rst = 1'b1;
        #1;
        check("arst req", sdram_req, 1'b0);
        check("arst addr", sdram_addr, 22'h0);
        check("arst ok", slot_ok, 4'h0);
        step();
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/jtkicker_sdram_arb.md
Name: jtkicker_sdram_arb

Overview:
- Shares the single SDRAM read port among four ROM requesters: scroll, object, PCM and main CPU.
- Each slot has a one-entry 32-bit cache, so repeated reads of the same address cost no SDRAM traffic.
- Contention is resolved round-robin. Each slot's offset is added before the request reaches the SDRAM.
- Sits between the video/main/sound blocks and the SDRAM controller, in the clk (48 MHz) domain.

Parameters:
- OFFSET0, 22'h0, SDRAM word offset added to slot 0 address (scroll).
- OFFSET1, 22'h0, SDRAM word offset added to slot 1 address (objects).
- OFFSET2, 22'h0, SDRAM word offset added to slot 2 address (PCM).
- OFFSET3, 22'h0, SDRAM word offset added to slot 3 address (main CPU).

Ports:
- clk  in  1  system clock, 48 MHz
- rst  in  1  asynchronous, active-high reset
- downloading  in  1  ROM download in progress
- slot_cs  in  4  per-slot read request, level
- slot_addr  in  88  four 22-bit word addresses; slot n is at [22n+21:22n]; bit 0 is always 0
- slot_ok  out  4  per-slot data valid for the current slot_addr
- slot_dout  out  128  four 32-bit cached words; slot n is at [32n+31:32n]
- sdram_req  out  1  read request to the SDRAM controller
- sdram_addr  out  22  request address = slot_addr + OFFSETn
- sdram_ack  in  1  one-cycle pulse: request accepted
- data_dst  in  1  data_read holds a valid 16-bit word this cycle
- data_rdy  in  1  pulses with the last word of the burst
- data_read  in  16  SDRAM read data

Behaviour:
- Reset values: sdram_req=0, sdram_addr=0, slot_ok=0, slot_dout=0, all cache-valid bits=0, FSM=IDLE, rr pointer=0.
- Cache per slot: tag (22 b), valid bit, data (32 b).
- Hit rule: slot_ok[n] = slot_cs[n] & valid[n] & (tag[n]==slot_addr[n]). This is combinational, so ok drops in the same cycle the address changes.
- FSM states: IDLE, REQ, WAIT, FILL.
- IDLE:
  - A slot misses when slot_cs=1 and the hit rule fails.
  - Among missing slots, grant the first found starting at rr pointer, searching upward modulo 4.
  - Latch grant index and slot_addr into a pending tag; drive sdram_addr = addr + OFFSETn; set sdram_req=1; go to REQ.
  - Latency: miss seen at cycle t → sdram_req high at t+1.
- REQ:
  - Hold sdram_req and sdram_addr stable until sdram_ack.
  - On ack: sdram_req=0 the next cycle; go to WAIT.
- WAIT / FILL:
  - First data_dst word goes to data[15:0]; go to FILL. The next data_dst word goes to data[31:16].
  - data_rdy together with the second word: write tag=pending tag, valid=1; go to IDLE; rr pointer = grant+1 (mod 4).
  - ok may assert the cycle after data_rdy.
- Ack and data_dst in the same cycle: legal. Take the word in that cycle.
- Stale request: if the granted slot's addr or cs changes during a request, complete the burst and fill the cache with the pending tag. The slot then misses and is re-arbitrated; the cache must never pair data with the wrong tag.
- Simultaneous misses: strictly round-robin. No slot waits more than 3 bursts.
- Offset addition: 22-bit, wraps modulo 2^22, no saturation.
- downloading=1:
  - Clear every valid bit; force slot_ok=0 and sdram_req=0; go to IDLE.
  - Words arriving during download are ignored. Arbitration resumes on the cycle downloading falls.
- Reset mid-burst: asynchronous; all state returns to reset values at once. Any in-flight data_dst/data_rdy is dropped.
- Only one burst is outstanding at a time.

Test Plan:
- Reset, then slot_cs=4'b0001, addr0=22'h000010, OFFSET0=22'h080000 → sdram_req=1 next cycle, sdram_addr=22'h080010. Ack plus words 16'h1234 then 16'h5678 with data_rdy → slot_dout[31:0]=32'h56781234, slot_ok[0]=1 the next cycle.
- Same addr re-read after the fill → slot_ok[0]=1 with no new sdram_req. Change addr0 to 22'h000012 → ok[0]=0 in the same cycle, new request to 22'h080012.
- slot_cs=4'b1111, all misses, rr=0 → grant order 0,1,2,3. After slot 3 is served, a new miss on slots 0 and 2 → 0 first (rr wrapped), then 2.
- Change addr1 from 22'h100 to 22'h200 while in WAIT → burst completes with tag 22'h100; then a new request is issued for 22'h200. ok[1] stays 0 until the second fill.
- Raise downloading during FILL → sdram_req=0, all ok=0, valid cleared. After it drops, a previously cached address misses and is refetched.
- Assert rst with sdram_req=1 → sdram_req=0 and sdram_addr=0 asynchronously, before the next clk edge.
